frame_uart_tx: RTL and testbench
================================

# frame_uart_tx

Reads a captured frame back out of the frame-buffer RAM, pixel by pixel in raster order, and sends each byte as 8N1 UART serial to the host PC. It sits on the RAM read side, opposite the OV7670 capture path. It drives the same line and column address bus and consumes the RAM `q` output. One `start` pulse streams the whole frame. `done` is pulsed when the last byte's stop bit ends.

## Interface

Parameters:
- `LINES`, 176, frame height in lines
- `COLUMNS`, 288, frame width in pixels
- `S_DATA`, 8, pixel width in bits; only 8 is supported
- `S_LINE`, 8, line address width
- `S_COLUMN`, 9, column address width
- `CLKS_PER_BIT`, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 2

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to transmit the whole frame; sampled only in IDLE
- `ram_q`  in  S_DATA  RAM read data, valid one cycle after the address is presented (registered read)
- `addr_line`  out  S_LINE  RAM line address
- `addr_column`  out  S_COLUMN  RAM column address
- `serial_tx`  out  1  UART line; idle high
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the last stop bit

## Operation

- FSM states: IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT, FINISH.
- IDLE:
  - `serial_tx`=1, `busy`=0.
  - Line and column counters are held at 0.
  - `start`=1 → FETCH.
- FETCH:
  - Addresses are stable on `addr_line`/`addr_column`.
  - The RAM registers the read; lasts 1 cycle → LOAD.
- LOAD:
  - `ram_q` is latched into an 8-bit shift register.
  - Baud counter and bit counter are cleared → START_BIT.
- START_BIT: `serial_tx`=0 for CLKS_PER_BIT cycles → DATA_BITS.
- DATA_BITS:
  - `serial_tx` = shift register bit 0 (LSB first).
  - After each CLKS_PER_BIT cycles, shift right and increment the 3-bit bit counter.
  - After 8 bits → STOP_BIT.
- STOP_BIT: `serial_tx`=1 for CLKS_PER_BIT cycles, then:
  - if line = LINES-1 and column = COLUMNS-1 → FINISH
  - otherwise → NEXT
- NEXT (1 cycle):
  - If column = COLUMNS-1, column wraps to 0 and line increments.
  - Otherwise column increments.
  - → FETCH.
- FINISH (1 cycle): `done`=1, counters cleared to 0 → IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. Its width is enough to hold CLKS_PER_BIT-1; terminal count is exactly CLKS_PER_BIT-1.
- `start` is ignored in every state other than IDLE, including FINISH.
- Reset, at any time including mid-byte, forces all of the following immediately (asynchronous):
  - state IDLE, `serial_tx`=1
  - `busy`=0, `done`=0
  - addresses 0, shift register 0
- `busy`=1 in every state except IDLE.

## Timing

- Reset values:
  - `serial_tx`=1
  - `busy`=0, `done`=0
  - `addr_line`=0, `addr_column`=0
- `start` high at edge N → FETCH in cycle N+1 (`busy`=1), LOAD in N+2, start bit begins in N+3.
- Each byte takes exactly 10·CLKS_PER_BIT + 3 cycles: FETCH + LOAD + 10 bits + NEXT/FINISH.
- Whole frame: `done` is high in cycle N + 1 + LINES·COLUMNS·(10·CLKS_PER_BIT+3) − 1. `busy` falls in the following cycle.
- Addresses change only on the edge leaving NEXT (or FINISH, back to 0). They are constant from FETCH through STOP_BIT of each byte.
- The RAM is never written by this block. Capture must not run concurrently; this is enforced at system level.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Reset values.** Assert `reset`=0 with `start`=1 → `serial_tx`=1, `busy`=0, `done`=0, addresses 0. Release reset → module stays idle until a fresh `start`.
- **Single byte frame.** LINES=1, COLUMNS=1, CLKS_PER_BIT=4, RAM[0][0]=0xA5, pulse `start`. Required response:
  - `serial_tx` = 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles, starting 3 cycles after `start`.
  - `done` pulses exactly 43 cycles after `start`.
- **Raster order and wrap.** LINES=2, COLUMNS=3, RAM holds 0x10..0x15 in raster order. Required response:
  - The decoded serial stream is 0x10,0x11,0x12,0x13,0x14,0x15.
  - The address sequence is (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - Addresses return to (0,0) after `done`.
- **Start while busy.** Pulse `start` again mid-frame and in the FINISH cycle → no restart or extra bytes; `done` pulses once at the original time.
- **Reset mid-byte.** Assert reset during DATA_BITS of byte 2 → `serial_tx`=1 within the same cycle (asynchronous). After release, a new `start` retransmits from pixel (0,0).
- **Back-to-back frames.** Pulse `start` in the cycle after `done` → the second frame's first start bit begins 3 cycles later, with identical byte content.

Source files
------------

// File: rtl/frame_uart_tx.sv
// Streams a captured frame out of the frame-buffer RAM in raster order as 8N1 UART bytes.
// One start pulse sends LINES*COLUMNS bytes. done pulses in the cycle after the last stop bit.
module frame_uart_tx #(
  parameter int LINES        = 176,
  parameter int COLUMNS      = 288,
  parameter int S_DATA       = 8,
  parameter int S_LINE       = 8,
  parameter int S_COLUMN     = 9,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [S_DATA-1:0]   ram_q,
  output logic [S_LINE-1:0]   addr_line,
  output logic [S_COLUMN-1:0] addr_column,
  output logic                serial_tx,
  output logic                busy,
  output logic                done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [S_LINE-1:0]   LINE_LAST = S_LINE'(LINES - 1);
  localparam logic [S_COLUMN-1:0] COL_LAST  = S_COLUMN'(COLUMNS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT, FINISH
  } state_t;

  state_t              state, state_next;
  logic [S_LINE-1:0]   line_next;
  logic [S_COLUMN-1:0] column_next;
  logic [S_DATA-1:0]   shift, shift_next;
  logic [BAUD_W-1:0]   baud, baud_next;
  logic [2:0]          bit_cnt, bit_next;
  logic                tx_next;

  always_comb begin
    state_next  = state;
    line_next   = addr_line;
    column_next = addr_column;
    shift_next  = shift;
    baud_next   = baud;
    bit_next    = bit_cnt;
    case (state)
      IDLE: begin
        line_next   = '0;
        column_next = '0;
        if (start) state_next = FETCH;
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        shift_next = ram_q;
        baud_next  = '0;
        bit_next   = '0;
        state_next = START_BIT;
      end
      START_BIT: begin
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          state_next = DATA_BITS;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      DATA_BITS: begin
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP_BIT;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      STOP_BIT: begin
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (addr_line == LINE_LAST && addr_column == COL_LAST) state_next = FINISH;
          else                                                   state_next = NEXT;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      NEXT: begin
        if (addr_column == COL_LAST) begin
          column_next = '0;
          line_next   = addr_line + 1'b1;
        end else begin
          column_next = addr_column + 1'b1;
        end
        state_next = FETCH;
      end
      FINISH: begin
        line_next   = '0;
        column_next = '0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Line value is computed from the next state so serial_tx can be a plain flop.
    tx_next = 1'b1;
    if (state_next == START_BIT)      tx_next = 1'b0;
    else if (state_next == DATA_BITS) tx_next = shift_next[0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_line   <= '0;
      addr_column <= '0;
      shift       <= '0;
      baud        <= '0;
      bit_cnt     <= '0;
      serial_tx   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      addr_line   <= line_next;
      addr_column <= column_next;
      shift       <= shift_next;
      baud        <= baud_next;
      bit_cnt     <= bit_next;
      serial_tx   <= tx_next;
      busy        <= (state_next != IDLE);
      done        <= (state_next == FINISH);
    end
  end

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed bench for frame_uart_tx: a 1x1 frame checked cycle by cycle from a table,
// and a 2x3 frame decoded from the serial line for raster order, restart and reset cases.
module tb_frame_uart_tx;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] ram_q_a, ram_q_b;
  logic [7:0] addr_line_a, addr_line_b;
  logic [8:0] addr_column_a, addr_column_b;
  logic       serial_tx_a, serial_tx_b, busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_b [6];

  always #5 clock = ~clock;

  frame_uart_tx #(.LINES(1), .COLUMNS(1), .CLKS_PER_BIT(CPB)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .ram_q(ram_q_a),
    .addr_line(addr_line_a), .addr_column(addr_column_a),
    .serial_tx(serial_tx_a), .busy(busy_a), .done(done_a)
  );

  frame_uart_tx #(.LINES(2), .COLUMNS(3), .CLKS_PER_BIT(CPB)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .ram_q(ram_q_b),
    .addr_line(addr_line_b), .addr_column(addr_column_b),
    .serial_tx(serial_tx_b), .busy(busy_b), .done(done_b)
  );

  // Registered-read RAM models: data follows the address by one clock.
  always @(posedge clock) begin
    int idx;
    ram_q_a <= 8'hA5;
    idx = int'(addr_line_b) * 3 + int'(addr_column_b);
    ram_q_b <= (idx < 6) ? mem_b[idx] : 8'h00;
  end

  typedef struct {
    int   first_k;
    int   last_k;
    logic tx;
    logic busy;
    logic done;
  } vec_t;

  localparam int NREC = 13;
  vec_t tbl [NREC];

  logic [7:0] rx_bytes [8];
  int         rx_line [8];
  int         rx_col  [8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle start; returns at the negedge just after the accepting edge (offset 0).
  task automatic applyStimulus(input bit to_a, input bit to_b);
    @(negedge clock);
    start_a = to_a;
    start_b = to_b;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: plain frame; 1: extra starts mid-frame and in FINISH;
  // 2: start in the cycle after done, returns at offset 0 of the next frame; 3: reset mid byte 2.
  task automatic run_frame_b(input int mode);
    int   nbytes, phase, done_k, done_cnt;
    bit   in_byte;
    logic [7:0] cur;
    nbytes = 0; phase = 0; done_k = -10; done_cnt = 0; in_byte = 0; cur = '0;
    for (int k = 0; k <= 262; k++) begin
      if (!in_byte) begin
        if (serial_tx_b == 1'b0) begin
          in_byte = 1;
          phase   = 0;
          if (nbytes == 0) checkOutput("first_start_offset", k, 2);
          if (nbytes < 8) begin
            rx_line[nbytes] = int'(addr_line_b);
            rx_col[nbytes]  = int'(addr_column_b);
          end
        end
      end else begin
        phase++;
        if (phase >= 6 && phase <= 34 && (phase - 6) % 4 == 0)
          cur[(phase - 6) / 4] = serial_tx_b;
        if (phase == 38) begin
          checkOutput("stop_bit", int'(serial_tx_b), 1);
          if (nbytes < 8) begin
            checkOutput("addr_line_stable", int'(addr_line_b), rx_line[nbytes]);
            checkOutput("addr_col_stable", int'(addr_column_b), rx_col[nbytes]);
            rx_bytes[nbytes] = cur;
          end
          nbytes++;
          in_byte = 0;
        end
      end

      if (done_b) begin
        done_cnt++;
        done_k = k;
      end
      if (k == done_k + 1) begin
        checkOutput("addr_line_after_done", int'(addr_line_b), 0);
        checkOutput("addr_col_after_done", int'(addr_column_b), 0);
        checkOutput("busy_after_done", int'(busy_b), 0);
      end

      if (mode == 3 && k == 60) begin
        checkOutput("tx_before_reset", int'(serial_tx_b), 0);
        reset = 1'b0;
        #1;
        checkOutput("tx_async_reset", int'(serial_tx_b), 1);
        checkOutput("busy_async_reset", int'(busy_b), 0);
        checkOutput("done_async_reset", int'(done_b), 0);
        checkOutput("col_async_reset", int'(addr_column_b), 0);
        return;
      end

      if (mode == 2 && k == done_k + 1) begin
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        break;
      end

      if (mode == 1) start_b = (k == 100) || done_b;
      if (k == 262) begin
        start_b = 1'b0;
        if (mode == 1) checkOutput("no_restart_busy", int'(busy_b), 0);
        break;
      end
      @(negedge clock);
    end
    start_b = 1'b0;

    checkOutput("byte_count", nbytes, 6);
    checkOutput("done_count", done_cnt, 1);
    checkOutput("done_offset", done_k, 6 * (10 * CPB + 3) - 1);
    for (int i = 0; i < 6 && i < nbytes; i++) begin
      checkOutput($sformatf("byte%0d", i), int'(rx_bytes[i]), 8'h10 + i);
      checkOutput($sformatf("line%0d", i), rx_line[i], i / 3);
      checkOutput($sformatf("col%0d", i), rx_col[i], i % 3);
    end
  endtask

  initial begin
    // 0xA5 LSB first: 1,0,1,0,0,1,0,1 after a 4-cycle start bit at offsets 2..5.
    tbl[0]  = '{0, 1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{2, 5, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{6, 9, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{10, 13, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{14, 17, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{18, 21, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{22, 25, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{26, 29, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{30, 33, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{34, 37, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{38, 41, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{42, 42, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{43, 45, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) mem_b[i] = 8'h10 + 8'(i);

    // Reset held with start high.
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_tx", int'(serial_tx_b), 1);
    checkOutput("rst_busy", int'(busy_b), 0);
    checkOutput("rst_done", int'(done_b), 0);
    checkOutput("rst_line", int'(addr_line_b), 0);
    checkOutput("rst_col", int'(addr_column_b), 0);
    checkOutput("rst_tx_a", int'(serial_tx_a), 1);
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("idle_busy_a", int'(busy_a), 0);
    checkOutput("idle_busy_b", int'(busy_b), 0);
    checkOutput("idle_tx_b", int'(serial_tx_b), 1);

    // Single byte frame, cycle by cycle.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 45; k++) begin
      for (int r = 0; r < NREC; r++) begin
        if (k >= tbl[r].first_k && k <= tbl[r].last_k) begin
          checkOutput($sformatf("a_tx_k%0d", k), int'(serial_tx_a), int'(tbl[r].tx));
          checkOutput($sformatf("a_busy_k%0d", k), int'(busy_a), int'(tbl[r].busy));
          checkOutput($sformatf("a_done_k%0d", k), int'(done_a), int'(tbl[r].done));
        end
      end
      if (k < 45) @(negedge clock);
    end

    // Raster order with starts while busy.
    applyStimulus(1'b0, 1'b1);
    run_frame_b(1);

    // Reset during byte 2, then a fresh frame from (0,0) followed back-to-back by another.
    applyStimulus(1'b0, 1'b1);
    run_frame_b(3);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("post_reset_busy", int'(busy_b), 0);
    applyStimulus(1'b0, 1'b1);
    run_frame_b(2);
    run_frame_b(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
